// File: rtl/xalu_seq_if.sv
// xalu_seq_if: operand/function request and result/status bus of the sequential ALU
interface xalu_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             com;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             co;
    logic             ovf;
    logic             equ;
    logic             zero;
    logic             neg_zero;
    modport master (
        output start, op, a, b, ci, com,
        input  busy, done, result, result_hi, co, ovf, equ, zero, neg_zero
    );
    modport slave (
        input  start, op, a, b, ci, com,
        output busy, done, result, result_hi, co, ovf, equ, zero, neg_zero
    );
endinterface

// File: rtl/xalu_seq.sv
// xalu_seq: sequential ALU with registered result/flags, start/done handshake, iterative shift/rotate/multiply
module xalu_seq #(parameter int WIDTH = 8) (
    input logic       clk,
    input logic       rst,
    xalu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW:0] NMUL = (CW+1)'(WIDTH);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
                           OP_PASSB = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8, OP_ROL = 4'd9, OP_MUL = 4'd10;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           r_state, w_nstate;
    logic [3:0]       r_op;
    logic             r_ci, r_com;
    logic [CW:0]      r_cnt;
    logic [WIDTH-1:0] r_acc, r_hi, r_mq;
    logic             r_done, r_co, r_ovf, r_equ, r_zero, r_nz;
    logic [WIDTH-1:0] r_res, r_rhi;

    logic [CW-1:0]    w_k;
    logic             w_arith, w_shift, w_multi, w_accept;
    logic [WIDTH-1:0] w_bs, w_sres;
    logic [WIDTH:0]   w_sum, w_madd;
    logic             w_sco, w_sovf;
    logic [WIDTH-1:0] w_sh, w_mhi, w_mlo;
    logic             w_shout;
    logic             w_fin, w_fcom, w_fco, w_fovf;
    logic [WIDTH-1:0] w_fres, w_fhi, w_out;

    // Single-cycle datapath evaluated on the live inputs at capture time
    assign w_k      = bus.b[CW-1:0];
    assign w_arith  = (bus.op == OP_ADD) || (bus.op == OP_SUB);
    assign w_shift  = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_ROL);
    assign w_multi  = (bus.op == OP_MUL) || (w_shift && (w_k != '0));
    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_bs     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    assign w_sum    = {1'b0, bus.a} + {1'b0, w_bs} + {{WIDTH{1'b0}}, bus.ci};
    assign w_sres   = w_arith ? w_sum[WIDTH-1:0] :
                      (bus.op == OP_AND)   ? (bus.a & bus.b) :
                      (bus.op == OP_OR)    ? (bus.a | bus.b) :
                      (bus.op == OP_XOR)   ? (bus.a ^ bus.b) :
                      (bus.op == OP_PASSB) ? bus.b : bus.a;
    assign w_sco    = w_arith && w_sum[WIDTH];
    assign w_sovf   = w_arith && (bus.a[WIDTH-1] == w_bs[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

    // One iteration step: single-bit shift/rotate, or one shift-add multiply step
    assign w_sh     = (r_op == OP_SHL) ? {r_acc[WIDTH-2:0], r_ci} :
                      (r_op == OP_SHR) ? {r_ci, r_acc[WIDTH-1:1]} : {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
    assign w_shout  = (r_op == OP_SHR) ? r_acc[0] : r_acc[WIDTH-1];
    assign w_madd   = {1'b0, r_hi} + (r_mq[0] ? {1'b0, r_acc} : '0);
    assign w_mhi    = w_madd[WIDTH:1];
    assign w_mlo    = {w_madd[0], r_mq[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nstate;
    end

    // Next state and the values committed to the outputs on completion
    always_comb begin
        w_nstate = r_state;
        w_fin    = 1'b0;
        w_fres   = w_sres;
        w_fhi    = '0;
        w_fco    = w_sco;
        w_fovf   = w_sovf;
        w_fcom   = bus.com;
        if (r_state == IDLE) begin
            if (bus.start) begin
                w_nstate = w_multi ? EXEC : IDLE;
                w_fin    = !w_multi;
            end
        end else if (r_cnt == 1) begin
            w_nstate = IDLE;
            w_fin    = 1'b1;
            w_fres   = (r_op == OP_MUL) ? w_mlo : w_sh;
            w_fhi    = (r_op == OP_MUL) ? w_mhi : '0;
            w_fco    = (r_op == OP_MUL) ? (w_mhi != '0) : w_shout;
            w_fovf   = 1'b0;
            w_fcom   = r_com;
        end
    end

    assign w_out = w_fcom ? ~w_fres : w_fres;

    // Operand capture, iteration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_ci   <= 1'b0;
            r_com  <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_mq   <= '0;
            r_done <= 1'b0;
            r_res  <= '0;
            r_rhi  <= '0;
            r_co   <= 1'b0;
            r_ovf  <= 1'b0;
            r_equ  <= 1'b0;
            r_zero <= 1'b0;
            r_nz   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_accept) begin
                r_op  <= bus.op;
                r_ci  <= bus.ci;
                r_com <= bus.com;
                r_equ <= (bus.a == bus.b);
                r_acc <= bus.a;
                r_hi  <= '0;
                r_mq  <= bus.b;
                r_cnt <= (bus.op == OP_MUL) ? NMUL : {1'b0, w_k};
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt - 1'b1;
                r_acc <= (r_op == OP_MUL) ? r_acc : w_sh;
                r_hi  <= w_mhi;
                r_mq  <= w_mlo;
            end
            if (w_fin) begin
                r_res  <= w_out;
                r_rhi  <= w_fhi;
                r_co   <= w_fco;
                r_ovf  <= w_fovf;
                r_zero <= (w_out == '0);
                r_nz   <= &w_out;
            end
        end
    end

    assign bus.busy      = (r_state == EXEC);
    assign bus.done      = r_done;
    assign bus.result    = r_res;
    assign bus.result_hi = r_rhi;
    assign bus.co        = r_co;
    assign bus.ovf       = r_ovf;
    assign bus.equ       = r_equ;
    assign bus.zero      = r_zero;
    assign bus.neg_zero  = r_nz;
endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: directed and randomized checks of xalu_seq against an arithmetic reference model
module tb_xalu_seq;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   e_res, e_hi, e_co, e_ovf, e_equ, e_zero, e_nz, e_lat;

    xalu_seq_if #(.WIDTH(8)) bus ();
    xalu_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results derived directly from the op definitions with integer arithmetic
    task automatic model(input int op, input int a, input int b, input int ci, input int com);
        int k, s, nb, p;
        k = b & 7;
        e_hi = 0; e_co = 0; e_ovf = 0; e_lat = 1;
        case (op)
            0: begin s = a + b + ci; e_res = s & 255; e_co = (s >> 8) & 1;
                     e_ovf = int'(((a >> 7) == (b >> 7)) && (((s >> 7) & 1) != (a >> 7))); end
            1: begin nb = ~b & 255; s = a + nb + ci; e_res = s & 255; e_co = (s >> 8) & 1;
                     e_ovf = int'(((a >> 7) == (nb >> 7)) && (((s >> 7) & 1) != (a >> 7))); end
            2: e_res = a & b;
            3: e_res = a | b;
            4: e_res = a ^ b;
            6: e_res = b;
            7: if (k == 0) e_res = a;
               else begin e_res = ((a << k) | (ci != 0 ? (1 << k) - 1 : 0)) & 255; e_co = (a >> (8 - k)) & 1; e_lat = 1 + k; end
            8: if (k == 0) e_res = a;
               else begin e_res = (a >> k) | (ci != 0 ? (255 & ~(255 >> k)) : 0); e_co = (a >> (k - 1)) & 1; e_lat = 1 + k; end
            9: if (k == 0) e_res = a;
               else begin e_res = ((a << k) | (a >> (8 - k))) & 255; e_co = e_res & 1; e_lat = 1 + k; end
            10: begin p = a * b; e_res = p & 255; e_hi = p >> 8; e_co = int'(e_hi != 0); e_lat = 9; end
            default: e_res = a;
        endcase
        if (com != 0) e_res = ~e_res & 255;
        e_zero = int'(e_res == 0);
        e_nz = int'(e_res == 255);
        e_equ = int'(a == b);
    endtask

    task automatic chk_outs();
        chk("result", 32'(bus.result), e_res);
        chk("result_hi", 32'(bus.result_hi), e_hi);
        chk("co", 32'(bus.co), e_co);
        chk("ovf", 32'(bus.ovf), e_ovf);
        chk("equ", 32'(bus.equ), e_equ);
        chk("zero", 32'(bus.zero), e_zero);
        chk("neg_zero", 32'(bus.neg_zero), e_nz);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the done cycle
    task automatic apply(input int op, input int a, input int b, input int ci, input int com, input int inj);
        int n;
        model(op, a, b, ci, com);
        bus.op = 4'(op); bus.a = 8'(a); bus.b = 8'(b); bus.ci = ci[0]; bus.com = com[0];
        bus.start = 1'b1;
        @(negedge clk);
        n = 1;
        while (bus.done !== 1'b1 && n < e_lat + 4) begin
            chk("busy_run", 32'(bus.busy), 1);
            if (n == inj) begin
                bus.start = 1'b1; bus.op = 4'd0; bus.a = 8'($urandom); bus.b = 8'($urandom);
            end else bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("done", 32'(bus.done), 1);
        chk("latency", n, e_lat);
        chk("busy_done", 32'(bus.busy), 0);
        chk_outs();
    endtask

    task automatic gap();
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("hold_result", 32'(bus.result), e_res);
        chk("hold_co", 32'(bus.co), e_co);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.com = 1'b0;
        repeat (3) @(negedge clk);
        e_res = 0; e_hi = 0; e_co = 0; e_ovf = 0; e_equ = 0; e_zero = 0; e_nz = 0;
        chk_outs();
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        apply(0, 8'h7F, 8'h01, 0, 0, 0);
        chk("add_ovf_lit", 32'(bus.result), 32'h80);
        gap();
        apply(1, 8'h05, 8'h05, 1, 0, 0);
        chk("sub_zero_lit", 32'(bus.zero), 1);
        apply(7, 8'h81, 3, 1, 0, 0);
        chk("shl_lit", 32'(bus.result), 32'h0F);
        apply(8, 8'h81, 1, 0, 0, 0);
        chk("shr_lit", 32'(bus.result), 32'h40);
        apply(9, 8'h81, 0, 0, 0, 0);
        gap();
        apply(10, 8'hFF, 8'hFF, 0, 0, 4);
        chk("mul_hi_lit", 32'(bus.result_hi), 32'hFE);
        gap();
        gap();
        apply(2, 8'hF0, 8'h0F, 0, 1, 0);
        chk("inv_lit", 32'(bus.result), 32'hFF);
        apply(6, 8'h33, 8'h00, 0, 0, 0);
        gap();
        // Reset during a multiply: abort, all outputs cleared, no done afterwards
        bus.op = 4'd10; bus.a = 8'hC3; bus.b = 8'h5A; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e_res = 0; e_hi = 0; e_co = 0; e_ovf = 0; e_equ = 0; e_zero = 0; e_nz = 0;
        chk_outs();
        chk("rst_mid_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 12; i++) begin
            chk("rst_mid_done", 32'(bus.done), 0);
            @(negedge clk);
        end
        apply(0, 8'h12, 8'h34, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 2) == 0) gap();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xalu_seq.md
# xalu_seq

Parametrised sequential ALU and the next generation of the team's 4-bit combinational ALU slice. It has a configurable data width, a registered result with registered status flags, and a start/done handshake. It adds subtract, multi-bit shift and rotate by count, and iterative unsigned multiply, each running over several cycles. It sits between the operand/function input registers and the result bus, and is driven by a sequencer that pulses `start` and waits for `done`.

## Interface
- `WIDTH`, default 8: operand and result width. Must be ≥ 4 and a power of two.
- `CW`, default $clog2(WIDTH): width of the shift count. Local; derived, not overridable.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  4  function code, captured with `start`.
- `a`  in  WIDTH  operand A, captured with `start`.
- `b`  in  WIDTH  operand B, captured with `start`. For shifts and rotates, `b[CW-1:0]` is the count.
- `ci`  in  1  carry-in or shift fill, captured with `start`.
- `com`  in  1  invert-result mode, captured with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  result, low word for MUL.
- `result_hi`  out  WIDTH  MUL high word; 0 for every other op.
- `co`  out  1  carry or shifted-out bit.
- `ovf`  out  1  signed overflow, ADD and SUB only.
- `equ`  out  1  captured A == B.
- `zero`  out  1  `result` all zeros.
- `neg_zero`  out  1  `result` all ones.

## Operation
- **Op codes**
  - 0 ADD: a+b+ci. `co` = carry out.
  - 1 SUB: a+~b+ci. `ci`=1 means no borrow; `co`=1 means no borrow out.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 PASSA.
  - 6 PASSB.
  - 7 SHL: shift left by k, fill from `ci`.
  - 8 SHR: shift right by k, fill from `ci`.
  - 9 ROL: rotate left by k.
  - 10 MUL: unsigned, 2·WIDTH-bit product.
  - 11–15: behave as PASSA.
- **States**
  - IDLE → EXEC on `start` for SHL/SHR/ROL with k≠0, and for MUL.
  - All other ops, and shifts or rotates with k=0, complete straight from IDLE.
  - EXEC → IDLE when the iteration counter expires.
- **Shift and rotate**
  - One bit position per cycle for k cycles; k = `b[CW-1:0]`.
  - `co` = the last bit shifted or rotated out. k=0: `result`=a, `co`=0.
- **MUL**
  - Shift-add, one multiplier bit per cycle, WIDTH cycles.
  - `co` = 1 if `result_hi` ≠ 0.
- **Overflow**
  - ADD: `ovf` = 1 when operand sign bits match and the result sign differs.
  - SUB: the same rule, applied to a and ~b.
  - `ovf` = 0 for all other ops.
- **Invert mode:** when captured `com`=1, `result` is inverted at completion. `result_hi`, `co` and `ovf` are not inverted.
- **Flags**
  - `zero` and `neg_zero` are registered from the final `result`, after inversion.
  - `equ` is registered at capture and held until the next capture.
- **Output updates:** all outputs update only at completion (`equ` at capture) and hold until the next operation completes.
- **Start while busy:** `start` is ignored while `busy`=1.
- **Reset**
  - Every output goes to 0 and the state goes to IDLE. This includes `zero`=0.
  - Reset mid-operation aborts it: no `done`, and partial results are discarded.

## Timing
- `start` is sampled high in cycle c. Latency L:
  - L = 1 for single-cycle ops and for k=0.
  - L = 1+k for shifts and rotates.
  - L = 1+WIDTH for MUL.
- `done`=1 in cycle c+L only. `result`, `result_hi` and flags are valid from cycle c+L.
- `busy`=1 in cycles c+1 … c+L−1. It is never high together with `done`.
- A new `start` is accepted in the `done` cycle, giving back-to-back single-cycle ops at one per cycle.
- `rst` has priority over `start`.

## Test plan
- **ADD overflow (WIDTH=8):** ADD a=0x7F b=0x01 ci=0 → `result`=0x80, `co`=0, `ovf`=1, `done` in c+1, `busy` never high.
- **SUB equal operands:** SUB a=0x05 b=0x05 ci=1 → `result`=0x00, `co`=1, `zero`=1, `equ`=1, `ovf`=0.
- **Shifts by count:**
  - SHL a=0x81 b=3 ci=1 → `result`=0x0F, `co`=0, `busy` in c+1..c+3, `done` in c+4.
  - SHR a=0x81 b=1 ci=0 → `result`=0x40, `co`=1.
  - ROL a=0x81 b=0 → `result`=0x81 in c+1.
- **MUL with ignored start:** MUL a=0xFF b=0xFF → `result`=0x01, `result_hi`=0xFE, `co`=1, `done` in c+9. A second `start` (ADD) pulsed in c+4 is ignored, with no extra `done`.
- **Invert mode:** `com`=1, AND a=0xF0 b=0x0F → `result`=0xFF, `neg_zero`=1, `zero`=0. Then PASSB b=0x00 with `com`=0 in the `done` cycle → `result`=0x00, `zero`=1 one cycle later.
- **Reset mid-operation:** assert `rst` in c+4 of a MUL → all outputs 0 next cycle, `done` never pulses, and a fresh ADD completes normally afterwards.
